// File: rtl/min_order_emitter.sv
// min_order_emitter: accepts four W-bit lane values in one handshake, then
// emits them one per transfer in ascending order (lowest lane index wins
// ties), each tagged with its original lane index.
// Optional build macro SORT_DESC_EN: emit largest first instead (same tie
// rule, same handshake and timing).
module min_order_emitter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [W-1:0] in_c,
   input  logic [W-1:0] in_d,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_val,
   output logic [1:0]   out_idx,
   output logic         out_last,
   output logic         busy
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_t;

   state_t       r_state;
   state_t       w_next_state;
   logic [3:0]   r_live;
   logic [3:0]   w_next_live;
   logic [W-1:0] r_val [4];
   logic         w_load;

   logic [1:0]   w_sel_idx;
   logic [W-1:0] w_sel_val;
   logic         w_found;

   // Pick the extreme value among live lanes; strict compare keeps the lowest index on ties.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' so later statements see the updated value;
      // every output gets a default first so no latch is inferred.
      w_sel_idx = 2'd0;
      w_sel_val = '0;
      w_found   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (r_live[i]) begin
`ifdef SORT_DESC_EN
            if (!w_found || (r_val[i] > w_sel_val)) begin
`else
            if (!w_found || (r_val[i] < w_sel_val)) begin
`endif
               w_found   = 1'b1;
               w_sel_idx = 2'(i);
               w_sel_val = r_val[i];
            end
         end
      end
   end

   // Next-state, live-mask update and registered-only output decode.
   always_comb begin
      w_next_state = r_state;
      w_next_live  = r_live;
      w_load       = 1'b0;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      out_val      = '0;
      out_idx      = 2'd0;
      out_last     = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_load       = 1'b1;
               w_next_live  = 4'b1111;
               w_next_state = S_EMIT;
            end
         end
         S_EMIT: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_val   = w_sel_val;
            out_idx   = w_sel_idx;
            out_last  = ($countones(r_live) == 1);
            if (out_ready) begin
               w_next_live = r_live & ~(4'b0001 << w_sel_idx);
               if (w_next_live == 4'b0000) begin
                  w_next_state = S_IDLE;
               end
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked blocks use non-blocking '<=' so all registers update together at the edge.
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Live mask and captured lane values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live <= 4'b0000;
         // NOTE: the four value registers are reset as well so a discarded group leaves
         // no stale data behind and the stored contents are defined after reset.
         for (int i = 0; i < 4; i++) begin
            r_val[i] <= '0;
         end
      end else begin
         r_live <= w_next_live;
         if (w_load) begin
            r_val[0] <= in_a;
            r_val[1] <= in_b;
            r_val[2] <= in_c;
            r_val[3] <= in_d;
         end
      end
   end

endmodule

// File: tb/tb_min_order_emitter.sv
// Testbench for min_order_emitter: expected (value, index, last) tuples are
// pushed to a scoreboard queue when a group is offered and popped as the DUT
// emits. Outputs are sampled 1 time unit after the rising edge.
module tb_min_order_emitter;

   localparam int W = 3;

   typedef struct {
      logic [W-1:0] val;
      logic [1:0]   idx;
      logic         last;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [W-1:0] in_c;
   logic [W-1:0] in_d;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_val;
   logic [1:0]   out_idx;
   logic         out_last;
   logic         busy;

   exp_t exp_q[$];
   int   n_vec;
   int   n_err;

   min_order_emitter #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .in_d      (in_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_val   (out_val),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Push the four expected transfers of one group; last flag on the fourth.
   task automatic expect_group(input logic [W-1:0] v0, input logic [1:0] i0,
                               input logic [W-1:0] v1, input logic [1:0] i1,
                               input logic [W-1:0] v2, input logic [1:0] i2,
                               input logic [W-1:0] v3, input logic [1:0] i3);
      exp_q.push_back('{val: v0, idx: i0, last: 1'b0});
      exp_q.push_back('{val: v1, idx: i1, last: 1'b0});
      exp_q.push_back('{val: v2, idx: i2, last: 1'b0});
      exp_q.push_back('{val: v3, idx: i3, last: 1'b1});
   endtask

   // Offer one group; waits (bounded) for in_ready, holds in_valid for one edge.
   task automatic send_group(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL send_ready: in_ready=%0b after %0d cycles, want 1", in_ready, n);
      end
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_c = c;
      in_d = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Drain four transfers with out_ready high, popping the scoreboard each cycle,
   // then confirm the block is back in IDLE the following cycle.
   task automatic collect_group(input string name);
      exp_t e;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s[%0d]: scoreboard empty, got val=%0d idx=%0d", name, k, out_val, out_idx);
         end else begin
            e = exp_q.pop_front();
            if ({out_valid, out_val, out_idx, out_last} !== {1'b1, e.val, e.idx, e.last}) begin
               n_err++;
               $display("FAIL %s[%0d]: got valid=%0b val=%0d idx=%0d last=%0b, want valid=1 val=%0d idx=%0d last=%0b",
                        name, k, out_valid, out_val, out_idx, out_last, e.val, e.idx, e.last);
            end
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      n_vec++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_err++;
         $display("FAIL %s_idle: got in_ready=%0b out_valid=%0b busy=%0b, want 1 0 0",
                  name, in_ready, out_valid, busy);
      end
   endtask

   task automatic test_reset();
      #2;
      n_vec++;
      if ({in_ready, out_valid, out_val, out_idx, out_last, busy} !== {1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_hold: got ready=%0b valid=%0b val=%0d idx=%0d last=%0b busy=%0b, want 1 0 0 0 0 0",
                  in_ready, out_valid, out_val, out_idx, out_last, busy);
      end
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if ({in_ready, out_valid, out_val, out_idx, out_last, busy} !== {1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_release: got ready=%0b valid=%0b val=%0d idx=%0d last=%0b busy=%0b, want 1 0 0 0 0 0",
                  in_ready, out_valid, out_val, out_idx, out_last, busy);
      end
   endtask

   task automatic test_ascending();
      expect_group(3'd1, 2'd0, 3'd2, 2'd1, 3'd3, 2'd2, 3'd4, 2'd3);
      send_group(3'd1, 3'd2, 3'd3, 3'd4);
      collect_group("ascending");
   endtask

   task automatic test_mixed();
      expect_group(3'd3, 2'd2, 3'd4, 2'd3, 3'd5, 2'd0, 3'd6, 2'd1);
      send_group(3'd5, 3'd6, 3'd3, 3'd4);
      collect_group("mixed_a");
      expect_group(3'd0, 2'd3, 3'd1, 2'd0, 3'd2, 2'd1, 3'd7, 2'd2);
      send_group(3'd1, 3'd2, 3'd7, 3'd0);
      collect_group("mixed_b");
   endtask

   task automatic test_ties();
      expect_group(3'd2, 2'd0, 3'd2, 2'd1, 3'd2, 2'd2, 3'd2, 2'd3);
      send_group(3'd2, 3'd2, 3'd2, 3'd2);
      collect_group("ties_all");
      expect_group(3'd1, 2'd1, 3'd1, 2'd3, 3'd4, 2'd0, 3'd4, 2'd2);
      send_group(3'd4, 3'd1, 3'd4, 3'd1);
      collect_group("ties_pairs");
   endtask

   // Stall three cycles while offering a conflicting group that must be ignored.
   task automatic test_backpressure();
      expect_group(3'd2, 2'd3, 3'd3, 2'd1, 3'd5, 2'd2, 3'd6, 2'd0);
      send_group(3'd6, 3'd3, 3'd5, 3'd2);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a = 3'd0;
      in_b = 3'd0;
      in_c = 3'd0;
      in_d = 3'd0;
      for (int s = 0; s < 3; s++) begin
         n_vec++;
         if ({out_valid, out_val, out_idx, out_last, in_ready, busy} !== {1'b1, 3'd2, 2'd3, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL stall[%0d]: got valid=%0b val=%0d idx=%0d last=%0b ready=%0b busy=%0b, want 1 2 3 0 0 1",
                     s, out_valid, out_val, out_idx, out_last, in_ready, busy);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      collect_group("backpressure");
   endtask

   // A second group held on in_valid during emission is taken the cycle in_ready returns.
   task automatic test_back_to_back();
      expect_group(3'd0, 2'd0, 3'd1, 2'd3, 3'd7, 2'd1, 3'd7, 2'd2);
      send_group(3'd0, 3'd7, 3'd7, 3'd1);
      in_valid = 1'b1;
      in_a = 3'd7;
      in_b = 3'd6;
      in_c = 3'd5;
      in_d = 3'd4;
      collect_group("b2b_first");
      expect_group(3'd4, 2'd3, 3'd5, 2'd2, 3'd6, 2'd1, 3'd7, 2'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      collect_group("b2b_second");
   endtask

   task automatic test_reset_mid_group();
      send_group(3'd7, 3'd2, 3'd4, 3'd5);
      out_ready = 1'b1;
      n_vec++;
      if ({out_valid, out_val, out_idx, out_last} !== {1'b1, 3'd2, 2'd1, 1'b0}) begin
         n_err++;
         $display("FAIL midrst_first: got valid=%0b val=%0d idx=%0d last=%0b, want 1 2 1 0",
                  out_valid, out_val, out_idx, out_last);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_vec++;
      if ({out_valid, out_val, out_idx} !== {1'b1, 3'd4, 2'd2}) begin
         n_err++;
         $display("FAIL midrst_second: got valid=%0b val=%0d idx=%0d, want 1 4 2", out_valid, out_val, out_idx);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({in_ready, out_valid, out_val, out_idx, out_last, busy} !== {1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL midrst_async: got ready=%0b valid=%0b val=%0d idx=%0d last=%0b busy=%0b, want 1 0 0 0 0 0",
                  in_ready, out_valid, out_val, out_idx, out_last, busy);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_err++;
         $display("FAIL midrst_after: got ready=%0b valid=%0b busy=%0b, want 1 0 0", in_ready, out_valid, busy);
      end
      expect_group(3'd0, 2'd2, 3'd1, 2'd1, 3'd4, 2'd3, 3'd5, 2'd0);
      send_group(3'd5, 3'd1, 3'd0, 3'd4);
      collect_group("midrst_next");
   endtask

   task automatic test_desc_order();
      expect_group(3'd7, 2'd2, 3'd2, 2'd1, 3'd1, 2'd0, 3'd0, 2'd3);
      send_group(3'd1, 3'd2, 3'd7, 3'd0);
      collect_group("desc_a");
      expect_group(3'd7, 2'd3, 3'd5, 2'd1, 3'd3, 2'd0, 3'd1, 2'd2);
      send_group(3'd3, 3'd5, 3'd1, 3'd7);
      collect_group("desc_b");
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_c      = '0;
      in_d      = '0;
      out_ready = 1'b0;
      test_reset();
`ifdef SORT_DESC_EN
      test_desc_order();
`else
      test_ascending();
      test_mixed();
      test_ties();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_group();
`endif
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/min_order_emitter.md
Name: min_order_emitter

Overview:
Consumer-side counterpart of the 4-way minimum-index comparator. It accepts a group of four W-bit values in one handshake. It then emits them one per transfer, smallest first, each tagged with its original lane index (0=a, 1=b, 2=c, 3=d). Downstream schedulers use it to service four lanes in ascending-key order.

Parameters:
W, 3, bit width of each value.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  group offered
in_ready  output  1  block can accept a group
in_a  input  W  lane 0 value
in_b  input  W  lane 1 value
in_c  input  W  lane 2 value
in_d  input  W  lane 3 value
out_valid  output  1  out_val/out_idx valid
out_ready  input  1  downstream accepts
out_val  output  W  emitted value
out_idx  output  2  original lane of emitted value
out_last  output  1  current output is final of the group
busy  output  1  group held (state EMIT)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, live mask=4'b0000, stored values=0, in_ready=1, out_valid=0, out_val=0, out_idx=0, out_last=0, busy=0.
- FSM states: IDLE and EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at a clock edge: register in_a..in_d, set live mask=4'b1111, go to EMIT.
- EMIT:
  - in_ready=0, busy=1, out_valid=1.
  - out_idx = index of the minimum value among live lanes; out_val = that value.
  - Ties resolve to the lowest index.
  - out_val/out_idx/out_last are decoded from registers only. They never depend combinationally on in_* or out_ready.
- Transfer: on out_valid && out_ready, clear the live bit of out_idx.
  - If that bit was the only live bit, go to IDLE.
- out_last=1 in EMIT when exactly one live bit remains; 0 otherwise.
- Latency and throughput:
  - First output is valid in the cycle after the accept edge.
  - With out_ready held high, 4 consecutive transfers follow.
  - in_ready returns the cycle after the last transfer, giving 5 cycles per group minimum.
- Backpressure: while out_valid && !out_ready, out_val, out_idx and out_last hold stable.
- in_valid in EMIT is ignored. The input is not captured, and the upstream must hold it under its own handshake.
- Comparisons are unsigned, full W bits, with no arithmetic widening.
- Reset asserted mid-group: immediate return to reset values. The partial group is discarded, and no further output is produced for it.
- out_valid never asserts in IDLE.

Optional Feature:
- Macro: SORT_DESC_EN.
- Defined: selection picks the maximum among live lanes, so values emit largest first. Tie rule stays lowest index. Handshake, timing and out_last are unchanged.
- Undefined: ascending (minimum-first) order as specified above.

Test Plan:
- Ascending group, out_ready=1: in (1,2,3,4) -> (val,idx) = (1,0),(2,1),(3,2),(4,3) on 4 consecutive cycles; out_last only on (4,3); in_ready high the cycle after.
- Mixed order: in (5,6,3,4) -> (3,2),(4,3),(5,0),(6,1). Then in (1,2,7,0) -> (0,3),(1,0),(2,1),(7,2).
- Ties: in (2,2,2,2) -> idx order 0,1,2,3, all val=2. In (4,1,4,1) -> (1,1),(1,3),(4,0),(4,2).
- Backpressure: in (6,3,5,2) with out_ready=0 for 3 cycles -> out_val=2, out_idx=3 held stable and in_ready=0 throughout. Then out_ready=1 -> (2,3),(3,1),(5,2),(6,0).
- Reset mid-group: in (7,2,4,5), after first transfer (2,1) pulse rst_n low -> out_valid=0 and in_ready=1 immediately (asynchronously). Next group (5,1,0,4) -> (0,2),(1,1),(4,3),(5,0).
- SORT_DESC_EN build: in (1,2,7,0) -> (7,2),(2,1),(1,0),(0,3). In (3,5,1,7) -> (7,3),(5,1),(3,0),(1,2).
